// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl: I2S MEMS mic array sequencer with warm-up discard, clean stop and per-channel sample streaming
module mic_capture_ctrl #(
  parameter int PRESCALE      = 12,
  parameter int N_LINES       = 2,
  parameter int SAMPLE_BITS   = 24,
  parameter int WARMUP_FRAMES = 4,
  localparam int NCH = 2 * N_LINES,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   sys_ck,
  input  logic                   rst,
  input  logic                   en,
  output logic                   sck,
  output logic                   ws,
  input  logic [N_LINES-1:0]     sd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SAMPLE_BITS-1:0] out_data,
  output logic [CW-1:0]          out_chan,
  output logic                   out_last,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic                   running
);
  localparam int PW = $clog2(PRESCALE);
  localparam int WW = $clog2(WARMUP_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, WARMUP, RUN, STOP} state_t;
  state_t                 r_state, w_next;
  logic [PW-1:0]          r_pre;
  logic [5:0]             r_bit;
  logic [WW-1:0]          r_wcnt;
  logic [SAMPLE_BITS-1:0] r_cap [NCH];
  logic [SAMPLE_BITS-1:0] r_buf [NCH];
  logic                   r_full, r_ovf;
  logic [CW-1:0]          r_rd;
  logic w_active, w_capt, w_wrap, w_fe, w_stb, w_lslot, w_rslot;
  logic w_load, w_drop, w_hs, w_done;

  always_ff @(posedge sys_ck) r_state <= rst ? IDLE : w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = en ? WARMUP : IDLE;
      WARMUP:  w_next = !en ? IDLE : (w_fe && r_wcnt == WW'(WARMUP_FRAMES - 1)) ? RUN : WARMUP;
      RUN:     w_next = en ? RUN : w_fe ? IDLE : STOP;
      default: w_next = w_fe ? IDLE : STOP;
    endcase
  end

  always_comb begin
    w_active = r_state != IDLE;
    w_capt   = r_state == RUN || r_state == STOP;
    running  = r_state == RUN;
  end

  // Bit slots 1..SAMPLE_BITS of each half-frame carry data (one-bit I2S delay after WS).
  always_comb begin
    w_wrap    = r_pre == PW'(PRESCALE - 1);
    w_fe      = w_active && w_wrap && r_bit == 6'd63;
    w_stb     = w_active && r_pre == PW'(PRESCALE / 2);
    w_lslot   = r_bit >= 6'd1 && r_bit <= 6'(SAMPLE_BITS);
    w_rslot   = r_bit >= 6'd33 && r_bit <= 6'(32 + SAMPLE_BITS);
    sck       = r_pre >= PW'(PRESCALE / 2);
    ws        = r_bit[5];
    w_load    = w_fe && w_capt && !r_full;
    w_drop    = w_fe && w_capt && r_full;
    w_hs      = r_full && out_ready;
    w_done    = w_hs && r_rd == CW'(NCH - 1);
    out_valid = r_full;
    out_data  = r_buf[r_rd];
    out_chan  = r_rd;
    out_last  = r_rd == CW'(NCH - 1);
    overflow  = r_ovf;
  end

  always_ff @(posedge sys_ck)
    if (rst || w_next == IDLE) begin
      r_pre <= '0;
      r_bit <= '0;
    end else if (w_active) begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      r_bit <= r_bit + 6'(w_wrap);
    end

  always_ff @(posedge sys_ck)
    r_wcnt <= (rst || r_state != WARMUP) ? '0 : r_wcnt + WW'(w_fe);

  always_ff @(posedge sys_ck)
    for (int c = 0; c < NCH; c++)
      if (rst) r_cap[c] <= '0;
      else if (w_stb && ((c % 2 == 1) ? w_rslot : w_lslot))
        r_cap[c] <= {r_cap[c][SAMPLE_BITS-2:0], sd[c / 2]};

  // A whole frame is handed over at once; a busy buffer means the new frame is dropped.
  always_ff @(posedge sys_ck)
    for (int c = 0; c < NCH; c++)
      if (rst) r_buf[c] <= '0;
      else if (w_load) r_buf[c] <= r_cap[c];

  always_ff @(posedge sys_ck)
    if (rst) begin
      r_full <= 1'b0;
      r_rd   <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_full <= w_load || (r_full && !w_done);
      r_rd   <= w_done ? '0 : r_rd + CW'(w_hs);
      r_ovf  <= w_drop || (r_ovf && !overflow_clr);
    end
endmodule

// File: tb/tb_mic_capture_ctrl.sv
// tb_mic_capture_ctrl: behavioural I2S mic pair driven by the DUT's SCK/WS, with a beat scoreboard
module tb_mic_capture_ctrl;
  localparam int PRESCALE = 12;
  logic        clk = 0, rst = 1, en = 0, out_ready = 1, overflow_clr = 0;
  logic [1:0]  sd = '0;
  logic        sck, ws, out_valid, out_last, overflow, running;
  logic [23:0] out_data;
  logic [1:0]  out_chan;
  int          n_vec = 0, n_err = 0;
  logic [26:0] exp_q [$];
  logic [23:0] nxt [4];
  logic [23:0] cur [4];

  always #5 clk = ~clk;

  mic_capture_ctrl #(.PRESCALE(PRESCALE), .N_LINES(2), .SAMPLE_BITS(24), .WARMUP_FRAMES(4)) dut (
    .sys_ck(clk), .rst(rst), .en(en), .sck(sck), .ws(ws), .sd(sd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .out_last(out_last), .overflow(overflow), .overflow_clr(overflow_clr), .running(running)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_pat(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c, input logic [23:0] d);
    nxt[0] = a;
    nxt[1] = b;
    nxt[2] = c;
    nxt[3] = d;
  endtask

  task automatic push_pat(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c, input logic [23:0] d);
    exp_q.push_back({1'b0, 2'd0, a});
    exp_q.push_back({1'b0, 2'd1, b});
    exp_q.push_back({1'b0, 2'd2, c});
    exp_q.push_back({1'b1, 2'd3, d});
  endtask

  // Returns one ns after the edge on which WS falls (frame end), with the cycles waited.
  task automatic wait_fe(output int cyc);
    logic p, got;
    p = ws;
    got = 0;
    cyc = 0;
    while (!got && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      got = p && !ws;
      p = ws;
    end
    chk("frame_end_seen", got, 1);
  endtask

  // Mic model: new slot on each SCK fall, slot 0 at each WS change; frame data latched at left-word start.
  logic sck_q = 0, ws_q = 0;
  int   slot = 0, sck_low = 0;
  always @(negedge clk) begin
    if (sck_q && !sck) begin
      slot = (ws != ws_q) ? 0 : slot + 1;
      if (ws_q && !ws) cur = nxt;
    end
    if (sck_low > PRESCALE) begin
      slot = 0;
      cur = nxt;
    end
    sck_low = sck ? 0 : sck_low + 1;
    for (int l = 0; l < 2; l++)
      sd[l] = (slot >= 1 && slot <= 24) ? cur[2 * l + int'(ws)][24 - slot] : 1'($urandom_range(0, 1));
    sck_q = sck;
    ws_q = ws;
  end

  logic        stalled = 0;
  logic [26:0] held = '0;
  always @(negedge clk) begin
    if (stalled && out_valid) chk("stall_hold", {out_last, out_chan, out_data}, held);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_beat", out_valid, 0);
      else chk("beat", {out_last, out_chan, out_data}, exp_q.pop_front());
    end
    stalled = out_valid && !out_ready && !rst;
    held = {out_last, out_chan, out_data};
  end

  initial begin
    int k, sr1, sr2, sf1, wr1, wr2, wf1, hi;
    logic sck_p, ws_p;
    sr1 = 0; sr2 = 0; sf1 = 0; wr1 = 0; wr2 = 0; wf1 = 0;
    set_pat(24'h800001, 24'h123456, 24'h7FFFFF, 24'h000000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", sck, 0);
    chk("rst_ws", ws, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_running", running, 0);
    rst = 0;
    en = 1;
    sck_p = 0;
    ws_p = 0;
    k = 0;
    while (!running && k < 4000) begin
      @(posedge clk);
      #1;
      k++;
      if (sck && !sck_p) begin
        if (sr1 == 0) sr1 = k;
        else if (sr2 == 0) sr2 = k;
      end
      if (!sck && sck_p && sf1 == 0) sf1 = k;
      if (ws && !ws_p) begin
        if (wr1 == 0) wr1 = k;
        else if (wr2 == 0) wr2 = k;
      end
      if (!ws && ws_p && wf1 == 0) wf1 = k;
      sck_p = sck;
      ws_p = ws;
    end
    chk("sck_first_rise", sr1, 7);
    chk("sck_period", sr2 - sr1, 12);
    chk("sck_high", sf1 - sr1, 6);
    chk("ws_low", wr1 - 1, 384);
    chk("ws_high", wf1 - wr1, 384);
    chk("ws_period", wr2 - wr1, 768);
    chk("run_at", k, 3073);

    push_pat(24'h800001, 24'h123456, 24'h7FFFFF, 24'h000000);
    wait_fe(k);
    repeat (10) @(posedge clk);
    #1;
    chk("t2_drain", exp_q.size(), 0);

    out_ready = 0;
    set_pat(24'hA5A5A5, 24'h5A5A5A, 24'h000001, 24'hFFFFFE);
    push_pat(24'h800001, 24'h123456, 24'h7FFFFF, 24'h000000);
    wait_fe(k);
    chk("t3_held_valid", out_valid, 1);
    chk("t3_no_ovf", overflow, 0);
    overflow_clr = 1;
    wait_fe(k);
    overflow_clr = 0;
    chk("t3_ovf_set_wins", overflow, 1);
    @(posedge clk);
    #1;
    chk("t3_ovf_sticky", overflow, 1);
    push_pat(24'hA5A5A5, 24'h5A5A5A, 24'h000001, 24'hFFFFFE);
    out_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("t3_drain", exp_q.size(), 4);
    overflow_clr = 1;
    @(posedge clk);
    #1;
    overflow_clr = 0;
    chk("t3_ovf_clr", overflow, 0);
    set_pat(24'hC0FFEE, 24'h0BEEF0, 24'hF00D00, 24'h00ACE0);
    wait_fe(k);

    push_pat(24'hC0FFEE, 24'h0BEEF0, 24'hF00D00, 24'h00ACE0);
    repeat (120) @(posedge clk);
    #1;
    en = 0;
    @(posedge clk);
    #1;
    chk("t4_stop", running, 0);
    repeat (100) @(posedge clk);
    #1;
    en = 1;
    @(posedge clk);
    #1;
    chk("t4_stop_ignores_en", running, 0);
    wait_fe(k);
    chk("t4_stop_len", k, 546);
    k = 0;
    while (!sck && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    en = 0;
    @(posedge clk);
    #1;
    chk("t4_abort_sck", sck, 0);
    chk("t4_abort_ws", ws, 0);
    chk("t4_abort_run", running, 0);
    hi = 0;
    repeat (900) begin
      @(posedge clk);
      #1;
      hi += int'(sck);
    end
    chk("t4_idle_quiet", hi, 0);
    chk("t4_drain", exp_q.size(), 0);

    set_pat(24'h13579B, 24'h2468AC, 24'hFEDCBA, 24'h012345);
    en = 1;
    k = 0;
    while (!running && k < 4000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t5_run_at", k, 3073);
    push_pat(24'h13579B, 24'h2468AC, 24'hFEDCBA, 24'h012345);
    wait_fe(k);
    for (int i = 0; i < 16; i++) begin
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
    end
    chk("t5_toggle_drain", exp_q.size(), 0);
    out_ready = 0;
    wait_fe(k);
    exp_q.push_back({1'b0, 2'd0, 24'h13579B});
    exp_q.push_back({1'b0, 2'd1, 24'h2468AC});
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_chan", out_chan, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_run", running, 0);
    chk("t5_rst_sck", sck, 0);
    out_ready = 1;
    repeat (50) @(posedge clk);
    #1;
    chk("t5_no_partial", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
